// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side request and pipeline-control bundle for hazard_scoreboard.
//   master: decoder side, drives dec_* / flush / stall_cnt_clr, receives enables, bubble, store_fwd, stall_cnt
//   slave : scoreboard side, the mirror of master
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  dec_valid;
    logic [6:0]            dec_opcode;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  flush;
    logic                  stall_cnt_clr;
    logic                  pc_en;
    logic                  if_id_en;
    logic                  dec_en;
    logic                  bubble;
    logic                  store_fwd;
    logic [CNT_W-1:0]      stall_cnt;
    modport master (
        output dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd, flush, stall_cnt_clr,
        input  pc_en, if_id_en, dec_en, bubble, store_fwd, stall_cnt
    );
    modport slave (
        input  dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd, flush, stall_cnt_clr,
        output pc_en, if_id_en, dec_en, bubble, store_fwd, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls decode on in-flight writes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hazard_scoreboard_if.slave (decode request in; PC/IF-ID/DEC enables, bubble,
//              store data forward select and saturating stall counter out)
`ifndef Opcode_Type_R_ALU
`define Opcode_Type_R_ALU    7'b0110011
`define Opcode_Type_I_ALU    7'b0010011
`define Opcode_Type_I_Load   7'b0000011
`define Opcode_Type_R_Store  7'b0100011
`define Opcode_Type_B_BRANCH 7'b1100011
`define Opcode_Type_U_LUI    7'b0110111
`define Opcode_Type_U_AUIPC  7'b0010111
`define Opcode_Type_J_JAL    7'b1101111
`define Opcode_Type_I_JALR   7'b1100111
`endif
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 2,
    parameter int ALU_LAT    = 0,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);
    localparam int NREG = 1 << REG_ADDR_W;
    logic [NREG-1:0][2:0]  pending_q, pending_d;
    logic [NREG-1:0]       pend_load_q, pend_load_d;
    logic [REG_ADDR_W-1:0] last_alu_rd_q, last_alu_rd_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic is_r, is_load, is_store, is_branch, rs1_used, rs2_used, writes_rd;
    logic fwd, hit1, hit2, stall, issue;
    always_comb begin
        is_r      = bus.dec_opcode == `Opcode_Type_R_ALU;
        is_load   = bus.dec_opcode == `Opcode_Type_I_Load;
        is_store  = bus.dec_opcode == `Opcode_Type_R_Store;
        is_branch = bus.dec_opcode == `Opcode_Type_B_BRANCH;
        rs1_used  = !(bus.dec_opcode == `Opcode_Type_U_LUI || bus.dec_opcode == `Opcode_Type_U_AUIPC
                      || bus.dec_opcode == `Opcode_Type_J_JAL);
        rs2_used  = is_r || is_store || is_branch;
        writes_rd = !(is_store || is_branch);
        // Load result arrives at the cache write-back path exactly when the store needs its data.
        fwd  = is_store && bus.dec_rs2 != '0 && pend_load_q[bus.dec_rs2] && pending_q[bus.dec_rs2] == 3'd1;
        // Branches compare in decode, so they cannot see the EX forward of the previous ALU op.
        hit1 = rs1_used && bus.dec_rs1 != '0
               && (pending_q[bus.dec_rs1] != 3'd0 || (is_branch && bus.dec_rs1 == last_alu_rd_q));
        hit2 = rs2_used && bus.dec_rs2 != '0
               && ((pending_q[bus.dec_rs2] != 3'd0 && !fwd) || (is_branch && bus.dec_rs2 == last_alu_rd_q));
        stall = !rst && bus.dec_valid && (hit1 || hit2) && !bus.flush;
        issue = bus.dec_valid && !stall && !bus.flush;
        bus.pc_en     = !stall;
        bus.if_id_en  = !stall;
        bus.dec_en    = !stall;
        bus.bubble    = !rst && (stall || bus.flush || !bus.dec_valid);
        bus.store_fwd = !rst && issue && fwd;
        bus.stall_cnt = stall_cnt_q;
        pending_d   = pending_q;
        pend_load_d = pend_load_q;
        for (int r = 0; r < NREG; r++) begin
            pending_d[r]   = pending_q[r] != 3'd0 ? pending_q[r] - 3'd1 : 3'd0;
            pend_load_d[r] = pend_load_q[r] && pending_q[r] > 3'd1;
            if (issue && r != 0 && bus.dec_rd == REG_ADDR_W'(r) && is_load) begin
                pending_d[r]   = 3'(LOAD_LAT);
                pend_load_d[r] = 1'b1;
            end else if (issue && r != 0 && bus.dec_rd == REG_ADDR_W'(r) && writes_rd && ALU_LAT > 0) begin
                pending_d[r]   = 3'(ALU_LAT);
                pend_load_d[r] = 1'b0;
            end
        end
        last_alu_rd_d = issue && writes_rd && !is_load ? bus.dec_rd : '0;
        stall_cnt_d   = bus.stall_cnt_clr ? '0 : stall && !(&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= '0;
            pend_load_q   <= '0;
            last_alu_rd_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            pending_q     <= pending_d;
            pend_load_q   <= pend_load_d;
            last_alu_rd_q <= last_alu_rd_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end
endmodule
